// File: rtl/codificador_4b5b_serial_pkg.sv
// Shared 4B5B code words, nibble code table, FSM state encoding and a
// helper that picks one bit of a 5-bit code in either transmit order.
package codificador_4b5b_serial_pkg;

    localparam logic [4:0] CODE_IDLE = 5'b11111;
    localparam logic [4:0] CODE_J    = 5'b11000;
    localparam logic [4:0] CODE_K    = 5'b10001;
    localparam logic [4:0] CODE_T    = 5'b01101;
    localparam logic [4:0] CODE_R    = 5'b00111;
    localparam logic [4:0] CODE_H    = 5'b00100;

    // Indexed by the nibble value 0..F.
    localparam logic [4:0] DATA_CODE [16] = '{
        5'b11110, 5'b01001, 5'b10100, 5'b10101,
        5'b01010, 5'b01011, 5'b01110, 5'b01111,
        5'b10010, 5'b10011, 5'b10110, 5'b10111,
        5'b11010, 5'b11011, 5'b11100, 5'b11101
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SSD_J,
        ST_SSD_K,
        ST_DATA,
        ST_ESD_T,
        ST_ESD_R,
        ST_HALT
    } state_t;

    // pos is the position within the symbol in transmit order (0 = first bit on the line).
    function automatic logic code_bit(input logic [4:0] code, input logic [2:0] pos,
                                      input bit msb_first);
        return msb_first ? code[3'd4 - pos] : code[pos];
    endfunction

endpackage

// File: rtl/codificador_4b5b_serial_if.sv
// Word handshake between the packet source (master) and the encoder (slave).
interface codificador_4b5b_serial_if #(
    parameter int NIBBLES = 2
);
    logic [4*NIBBLES-1:0] in_data;
    logic                 in_last;
    logic                 in_valid;
    logic                 in_ready;

    modport master (output in_data, output in_last, output in_valid, input in_ready);
    modport slave  (input in_data, input in_last, input in_valid, output in_ready);
endinterface

// File: rtl/codificador_4b5b_serial_lut.sv
// Combinational nibble -> 5-bit 4B5B data code.
module codificador_4b5b_lut
    import codificador_4b5b_serial_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [4:0] code
);
    assign code = DATA_CODE[nibble];
endmodule

// File: rtl/codificador_4b5b_serial.sv
// 4B5B line encoder: frames words as J K <data> T R with IDLE between frames and
// serialises one bit per clock. Symbol decisions are taken once per symbol at bit_cnt == 4.
module codificador_4b5b_serial
    import codificador_4b5b_serial_pkg::*;
#(
    parameter int NIBBLES   = 2,
    parameter bit NRZI      = 1'b0,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset,
    codificador_4b5b_serial_if.slave in_bus,
    output logic                     tx_bit,
    output logic                     sym_start,
    output logic                     underrun
);
    // state    | meaning
    // ST_IDLE  | between frames, sending IDLE symbols
    // ST_SSD_J | first start delimiter (J)
    // ST_SSD_K | second start delimiter (K)
    // ST_DATA  | sending nibble nib_idx of the active word
    // ST_ESD_T | end delimiter T
    // ST_ESD_R | end delimiter R
    // ST_HALT  | frame aborted for lack of data, sending H

    localparam int W     = 4 * NIBBLES;
    localparam int NIB_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t           state, nxt_state;
    logic [2:0]       bit_cnt, nxt_pos;
    logic [4:0]       cur_code, nxt_code, lut_code;
    logic [3:0]       lut_nib;
    logic [W-1:0]     hold_data, act_data, act_next;
    logic             hold_full, hold_last, act_last;
    logic [NIB_W-1:0] nib_idx;
    logic             sym_end, nib_last, accept, load_act, adv_nib, start_halt, line_bit;

    assign sym_end         = (bit_cnt == 3'd4);
    assign nib_last        = (nib_idx == NIB_W'(NIBBLES - 1));
    assign act_next        = act_data >> 4;
    assign in_bus.in_ready = !hold_full && !reset;
    assign accept          = in_bus.in_valid && in_bus.in_ready;
    assign nxt_pos         = sym_end ? 3'd0 : bit_cnt + 3'd1;
    assign line_bit        = code_bit(sym_end ? nxt_code : cur_code, nxt_pos, MSB_FIRST);

    // Only a fresh word from hold or the next nibble of the active word is ever encoded.
    assign lut_nib = (state == ST_SSD_K || (state == ST_DATA && nib_last))
                     ? hold_data[3:0] : act_next[3:0];

    codificador_4b5b_lut u_lut (
        .nibble (lut_nib),
        .code   (lut_code)
    );

    always_comb begin
        nxt_state  = state;
        nxt_code   = CODE_IDLE;
        load_act   = 1'b0;
        adv_nib    = 1'b0;
        start_halt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hold_full) begin
                    nxt_state = ST_SSD_J;
                    nxt_code  = CODE_J;
                end
            end
            ST_SSD_J: begin
                nxt_state = ST_SSD_K;
                nxt_code  = CODE_K;
            end
            ST_SSD_K: begin
                nxt_state = ST_DATA;
                nxt_code  = lut_code;
                load_act  = 1'b1;
            end
            ST_DATA: begin
                if (!nib_last) begin
                    nxt_code = lut_code;
                    adv_nib  = 1'b1;
                end else if (act_last) begin
                    nxt_state = ST_ESD_T;
                    nxt_code  = CODE_T;
                end else if (hold_full) begin
                    nxt_code = lut_code;
                    load_act = 1'b1;
                end else begin
                    nxt_state  = ST_HALT;
                    nxt_code   = CODE_H;
                    start_halt = 1'b1;
                end
            end
            ST_ESD_T: begin
                nxt_state = ST_ESD_R;
                nxt_code  = CODE_R;
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= 3'd0;
            cur_code  <= CODE_IDLE;
            tx_bit    <= 1'b0;
            sym_start <= 1'b0;
            underrun  <= 1'b0;
            hold_full <= 1'b0;
            hold_data <= '0;
            hold_last <= 1'b0;
            act_data  <= '0;
            act_last  <= 1'b0;
            nib_idx   <= '0;
        end else begin
            tx_bit    <= NRZI ? (tx_bit ^ line_bit) : line_bit;
            sym_start <= sym_end;
            underrun  <= sym_end && start_halt;
            hold_full <= (hold_full && !(sym_end && load_act)) || accept;
            if (accept) begin
                hold_data <= in_bus.in_data;
                hold_last <= in_bus.in_last;
            end
            if (sym_end) begin
                bit_cnt  <= 3'd0;
                state    <= nxt_state;
                cur_code <= nxt_code;
                if (load_act) begin
                    act_data <= hold_data;
                    act_last <= hold_last;
                    nib_idx  <= '0;
                end else if (adv_nib) begin
                    act_data <= act_next;
                    nib_idx  <= nib_idx + NIB_W'(1);
                end
            end else begin
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_codificador_4b5b_serial.sv
// Bench for the 4B5B serial encoder: three instances (plain MSB-first, NRZI, LSB-first)
// share one input stream and are compared every cycle against a symbol-queue model.
module tb_codificador_4b5b_serial;

    localparam logic [4:0] S_IDLE = 5'b11111;
    localparam logic [4:0] S_J    = 5'b11000;
    localparam logic [4:0] S_K    = 5'b10001;
    localparam logic [4:0] S_T    = 5'b01101;
    localparam logic [4:0] S_R    = 5'b00111;
    localparam logic [4:0] S_H    = 5'b00100;

    logic [4:0] code_tbl [16] = '{
        5'b11110, 5'b01001, 5'b10100, 5'b10101, 5'b01010, 5'b01011, 5'b01110, 5'b01111,
        5'b10010, 5'b10011, 5'b10110, 5'b10111, 5'b11010, 5'b11011, 5'b11100, 5'b11101
    };

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       last  = 1'b0;
    int         checks = 0;
    int         errors = 0;

    always #5 clock = ~clock;

    codificador_4b5b_serial_if #(.NIBBLES(2)) bus0 ();
    codificador_4b5b_serial_if #(.NIBBLES(2)) bus1 ();
    codificador_4b5b_serial_if #(.NIBBLES(2)) bus2 ();

    assign bus0.in_valid = valid;
    assign bus0.in_data  = data;
    assign bus0.in_last  = last;
    assign bus1.in_valid = valid;
    assign bus1.in_data  = data;
    assign bus1.in_last  = last;
    assign bus2.in_valid = valid;
    assign bus2.in_data  = data;
    assign bus2.in_last  = last;

    logic tx0, tx1, tx2, ss0, ss1, ss2, ur0, ur1, ur2;

    codificador_4b5b_serial #(.NIBBLES(2), .NRZI(1'b0), .MSB_FIRST(1'b1)) dut0 (
        .clock(clock), .reset(reset), .in_bus(bus0), .tx_bit(tx0), .sym_start(ss0), .underrun(ur0));
    codificador_4b5b_serial #(.NIBBLES(2), .NRZI(1'b1), .MSB_FIRST(1'b1)) dut1 (
        .clock(clock), .reset(reset), .in_bus(bus1), .tx_bit(tx1), .sym_start(ss1), .underrun(ur1));
    codificador_4b5b_serial #(.NIBBLES(2), .NRZI(1'b0), .MSB_FIRST(1'b0)) dut2 (
        .clock(clock), .reset(reset), .in_bus(bus2), .tx_bit(tx2), .sym_start(ss2), .underrun(ur2));

    // Model: accepted words wait in m_wq; scheduled symbols wait in m_sq.
    typedef struct { logic [7:0] d; logic l; } word_t;
    word_t      m_wq[$];
    logic [4:0] m_sq[$];
    bit         m_in_frame = 1'b0;
    int         m_cnt = 0;
    logic [4:0] m_cur = S_IDLE;
    logic       m_tx0 = 1'b0, m_tx1 = 1'b0, m_tx2 = 1'b0, m_start = 1'b0, m_under = 1'b0;

    logic [4:0] cap_q[$];
    logic [4:0] cap_acc = 5'd0;
    int         cap_k = 0;
    int         ur_count = 0;

    task automatic model_boundary(output logic [4:0] s);
        word_t w;
        if (m_sq.size() > 0) begin
            s = m_sq.pop_front();
        end else if (m_in_frame) begin
            if (m_wq.size() > 0) begin
                w = m_wq.pop_front();
                s = code_tbl[w.d[3:0]];
                m_sq.push_back(code_tbl[w.d[7:4]]);
                if (w.l) begin
                    m_sq.push_back(S_T);
                    m_sq.push_back(S_R);
                    m_sq.push_back(S_IDLE);
                    m_in_frame = 1'b0;
                end
            end else begin
                s = S_H;
                m_sq.push_back(S_IDLE);
                m_in_frame = 1'b0;
            end
        end else if (m_wq.size() > 0) begin
            s = S_J;
            m_sq.push_back(S_K);
            m_in_frame = 1'b1;
        end else begin
            s = S_IDLE;
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    always @(posedge clock) begin : model
        logic [4:0] s;
        logic       acc;
        word_t      w;
        if (reset) begin
            m_wq.delete();
            m_sq.delete();
            m_in_frame = 1'b0;
            m_cnt   = 0;
            m_cur   = S_IDLE;
            m_tx0   = 1'b0;
            m_tx1   = 1'b0;
            m_tx2   = 1'b0;
            m_start = 1'b0;
            m_under = 1'b0;
        end else begin
            acc = valid && (m_wq.size() == 0);
            if (m_cnt == 4) begin
                model_boundary(s);
                m_cur   = s;
                m_cnt   = 0;
                m_start = 1'b1;
                m_under = (s == S_H);
            end else begin
                m_cnt++;
                m_start = 1'b0;
                m_under = 1'b0;
            end
            m_tx0 = m_cur[3'(4 - m_cnt)];
            m_tx1 = m_tx1 ^ m_tx0;
            m_tx2 = m_cur[3'(m_cnt)];
            if (acc) begin
                w.d = data;
                w.l = last;
                m_wq.push_back(w);
            end
        end
        #1;
        check_bit("tx_msb", tx0, m_tx0);
        check_bit("tx_nrzi", tx1, m_tx1);
        check_bit("tx_lsb", tx2, m_tx2);
        check_bit("sym_start0", ss0, m_start);
        check_bit("sym_start1", ss1, m_start);
        check_bit("sym_start2", ss2, m_start);
        check_bit("underrun0", ur0, m_under);
        check_bit("underrun1", ur1, m_under);
        check_bit("underrun2", ur2, m_under);
        check_bit("in_ready0", bus0.in_ready, (m_wq.size() == 0) && !reset);
        check_bit("in_ready1", bus1.in_ready, (m_wq.size() == 0) && !reset);
        check_bit("in_ready2", bus2.in_ready, (m_wq.size() == 0) && !reset);
        // Rebuild line symbols from the MSB-first instance for frame-level checks.
        if (reset) begin
            cap_k = 0;
        end else if (ss0 === 1'b1) begin
            cap_acc = {4'b0000, tx0};
            cap_k   = 1;
        end else if (cap_k > 0) begin
            cap_acc = {cap_acc[3:0], tx0};
            cap_k++;
        end
        if (cap_k == 5) begin
            cap_q.push_back(cap_acc);
            cap_k = 0;
        end
        if (ur0 === 1'b1) ur_count++;
    end

    task automatic send_word(input logic [7:0] d, input logic l, input bit keep);
        int n = 0;
        @(negedge clock);
        valid = 1'b1;
        data  = d;
        last  = l;
        while (bus0.in_ready !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL send_word %02h: in_ready stayed %b, required 1 within 200 cycles", d, bus0.in_ready);
        end
        @(negedge clock);
        if (!keep) valid = 1'b0;
    endtask

    task automatic check_frame(input string name, input logic [4:0] exp [8], input int n);
        int idx = -1;
        for (int i = 0; i < cap_q.size(); i++)
            if (idx < 0 && cap_q[i] !== S_IDLE) idx = i;
        checks++;
        if (idx < 0) begin
            errors++;
            $display("FAIL %s: saw %0d IDLE-only symbols, required a J", name, cap_q.size());
            return;
        end
        for (int j = 0; j <= n; j++) begin
            logic [4:0] e;
            logic [4:0] a;
            e = (j < n) ? exp[j] : S_IDLE;
            a = (idx + j < cap_q.size()) ? cap_q[idx + j] : 5'bxxxxx;
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s sym%0d: got %b expected %b", name, j, a, e);
            end
        end
    endtask

    typedef struct { logic [7:0] word; logic [4:0] lo; logic [4:0] hi; } vec_t;
    vec_t vecs [9];

    initial begin
        logic [4:0] fr [8];
        int         n;
        int         bad;
        vecs[0] = '{8'h5A, 5'b10110, 5'b01011};
        vecs[1] = '{8'h10, 5'b11110, 5'b01001};
        vecs[2] = '{8'h32, 5'b10100, 5'b10101};
        vecs[3] = '{8'h54, 5'b01010, 5'b01011};
        vecs[4] = '{8'h76, 5'b01110, 5'b01111};
        vecs[5] = '{8'h98, 5'b10010, 5'b10011};
        vecs[6] = '{8'hBA, 5'b10110, 5'b10111};
        vecs[7] = '{8'hDC, 5'b11010, 5'b11011};
        vecs[8] = '{8'hFE, 5'b11100, 5'b11101};

        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (25) @(negedge clock);

        for (int v = 0; v < 9; v++) begin
            cap_q.delete();
            send_word(vecs[v].word, 1'b1, 1'b0);
            repeat (55) @(negedge clock);
            fr = '{S_J, S_K, vecs[v].lo, vecs[v].hi, S_T, S_R, S_IDLE, S_IDLE};
            check_frame($sformatf("frame_%02h", vecs[v].word), fr, 6);
        end

        cap_q.delete();
        send_word(8'h01, 1'b0, 1'b1);
        send_word(8'h23, 1'b1, 1'b0);
        repeat (70) @(negedge clock);
        fr = '{S_J, S_K, 5'b01001, 5'b11110, 5'b10101, 5'b10100, S_T, S_R};
        check_frame("two_word", fr, 8);

        cap_q.delete();
        ur_count = 0;
        send_word(8'h00, 1'b0, 1'b0);
        repeat (55) @(negedge clock);
        fr = '{S_J, S_K, 5'b11110, 5'b11110, S_H, S_IDLE, S_IDLE, S_IDLE};
        check_frame("underrun_frame", fr, 5);
        checks++;
        if (ur_count != 1) begin
            errors++;
            $display("FAIL underrun_pulses: got %0d expected 1", ur_count);
        end

        send_word(8'h5A, 1'b1, 1'b0);
        n = 0;
        while (!(m_cur == 5'b01011 && m_cnt == 2) && n < 200) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL reset_wait: second data symbol not reached, got %0d cycles limit 200", n);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        cap_q.delete();
        ur_count = 0;
        repeat (40) @(negedge clock);
        bad = 0;
        foreach (cap_q[i]) if (cap_q[i] !== S_IDLE) bad++;
        checks++;
        if (cap_q.size() < 6 || bad != 0) begin
            errors++;
            $display("FAIL reset_abort: got %0d symbols with %0d non-IDLE, expected >=6 all IDLE", cap_q.size(), bad);
        end
        checks++;
        if (ur_count != 0) begin
            errors++;
            $display("FAIL reset_underrun: got %0d pulses expected 0", ur_count);
        end

        for (int c = 0; c < 4000; c++) begin
            @(negedge clock);
            valid = ($urandom_range(0, 99) < 35);
            data  = 8'($urandom);
            last  = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 799) == 0);
        end
        @(negedge clock);
        valid = 1'b0;
        reset = 1'b0;
        repeat (20) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
